// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (double dabble, one bit per clock).
// Valid/ready handshake on both sides; results are registered and held until the next DONE.
// Optional leading-zero blanking is enabled by defining BIN2BCD_BLANK_EN; otherwise blank is tied to 0.
module bin2bcd_seq #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [IN_W-1:0]  bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic             ovf_sr;
  logic [CNT_W-1:0] cnt;

  logic [BCD_W-1:0] adj_s;
  logic [BCD_W-1:0] shifted_s;
  logic             ovf_next_s;

  // Add 3 to every digit that is 5 or more, so the following shift carries correctly.
  function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_r;

  // Digit i (i>=1) is blanked when it and every higher digit are zero; digit 0 is never blanked.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] v);
    logic              zero_above;
    logic [DIGITS-1:0] m;
    zero_above = 1'b1;
    m = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (v[4*i +: 4] == 4'd0);
      m[i] = zero_above;
    end
    return m;
  endfunction

  assign blank = blank_r;
`else
  assign blank = '0;
`endif

  assign in_ready = (state == IDLE);

  // One double-dabble step: adjust, shift in the binary MSB, track bits lost off the top digit.
  always_comb begin
    adj_s      = add3_adjust(bcd_sr);
    shifted_s  = {adj_s[BCD_W-2:0], bin_sr[IN_W-1]};
    ovf_next_s = ovf_sr | adj_s[BCD_W-1];
  end

  // Control FSM with conversion datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin_sr    <= '0;
      bcd_sr    <= '0;
      ovf_sr    <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      bcd       <= '0;
      overflow  <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
      blank_r   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_sr <= bin;
            bcd_sr <= '0;
            ovf_sr <= 1'b0;
            cnt    <= CNT_LOAD;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_sr <= shifted_s;
          bin_sr <= bin_sr << 1;
          ovf_sr <= ovf_next_s;
          cnt    <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            // Last bit: publish the result on the same edge that enters DONE.
            state     <= DONE;
            out_valid <= 1'b1;
            bcd       <= ovf_next_s ? ALL_NINES : shifted_s;
            overflow  <= ovf_next_s;
`ifdef BIN2BCD_BLANK_EN
            blank_r   <= ovf_next_s ? '0 : blank_mask(shifted_s);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
